// File: rtl/pwb_pkg.sv
// Shared definitions for the pixel write buffer: drain FSM state codes,
// per-frame output mode encodings and the words-per-frame helper.
package pwb_pkg;

    // Drain FSM state codes
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_STROBE  = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    // Per-frame output mode
    localparam logic MODE_REPL = 1'b0;
    localparam logic MODE_PACK = 1'b1;

    // Number of output words a frame produces in the given mode
    function automatic int unsigned word_count(input logic mode,
                                               input int unsigned num_pix,
                                               input int unsigned lanes);
        if (mode == MODE_PACK) begin
            return (num_pix + lanes - 32'd1) / lanes;
        end
        return num_pix;
    endfunction

endpackage

// File: rtl/pixel_write_buffer_if.sv
// Bus bundle between the filter stage / write controller and pixel_write_buffer.
//  master : drives capture inputs and write-complete, observes buffer outputs
//  slave  : the buffer itself
// o_overflow_count exists only when PWB_OVF_CNT_EN is defined.
interface pixel_write_buffer_if #(
    parameter int unsigned NUM_PIX = 9,
    parameter int unsigned PIX_W   = 8,
    parameter int unsigned DATA_W  = 32
);
    logic [NUM_PIX*PIX_W-1:0] i_processed_sum;
    logic                     i_pack_mode;
    logic                     i_save;
    logic                     i_write_complete;
    logic                     o_empty;
    logic                     o_full;
    logic [DATA_W-1:0]        o_write_data;
    logic                     o_write_enable;
`ifdef PWB_OVF_CNT_EN
    logic [7:0]               o_overflow_count;

    modport master (
        output i_processed_sum, i_pack_mode, i_save, i_write_complete,
        input  o_empty, o_full, o_write_data, o_write_enable, o_overflow_count
    );
    modport slave (
        input  i_processed_sum, i_pack_mode, i_save, i_write_complete,
        output o_empty, o_full, o_write_data, o_write_enable, o_overflow_count
    );
`else
    modport master (
        output i_processed_sum, i_pack_mode, i_save, i_write_complete,
        input  o_empty, o_full, o_write_data, o_write_enable
    );
    modport slave (
        input  i_processed_sum, i_pack_mode, i_save, i_write_complete,
        output o_empty, o_full, o_write_data, o_write_enable
    );
`endif
endinterface

// File: rtl/pwb_bank.sv
// One storage bank of the pixel write buffer: holds a captured frame and its
// output mode plus a valid flag. load has priority over clear.
//  clk, rst          : clock, synchronous active-high reset
//  load, clear       : capture a frame / free the bank
//  pix_in, mode_in   : frame data and mode to capture
//  pix, mode, valid  : stored frame, mode and occupancy
module pwb_bank
    import pwb_pkg::*;
#(
    parameter int unsigned NUM_PIX = 9,
    parameter int unsigned PIX_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     clear,
    input  logic [NUM_PIX*PIX_W-1:0] pix_in,
    input  logic                     mode_in,
    output logic [NUM_PIX*PIX_W-1:0] pix,
    output logic                     mode,
    output logic                     valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pix   <= '0;
            mode  <= MODE_REPL;
            valid <= 1'b0;
        end else if (load) begin
            pix   <= pix_in;
            mode  <= mode_in;
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pixel_write_buffer.sv
// Double-banked pixel write buffer. Captures NUM_PIX pixels per i_save into a
// ping-pong bank and drains each frame to the write controller one word per
// strobe / write-complete handshake, replicated or packed per frame.
//  clk, rst : clock, synchronous active-high reset
//  bus      : pixel_write_buffer_if.slave (capture inputs, write handshake, flags)
// Optional: define PWB_OVF_CNT_EN to add the saturating dropped-save counter.
module pixel_write_buffer
    import pwb_pkg::*;
#(
    parameter int unsigned NUM_PIX = 9,
    parameter int unsigned PIX_W   = 8,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    pixel_write_buffer_if.slave   bus
);

    localparam int unsigned LANES      = DATA_W / PIX_W;
    localparam int unsigned PIX_BITS   = NUM_PIX * PIX_W;
    localparam int unsigned IDX_W      = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
    localparam int unsigned PACK_WORDS = word_count(MODE_PACK, NUM_PIX, LANES);
    localparam int unsigned PW_IDX_W   = (PACK_WORDS > 1) ? $clog2(PACK_WORDS) : 1;
    localparam int unsigned REPL_LAST  = word_count(MODE_REPL, NUM_PIX, LANES) - 1;
    localparam int unsigned PACK_LAST  = PACK_WORDS - 1;

    logic [2:0]          state, state_next;
    logic                wr_ptr, rd_ptr;
    logic [IDX_W-1:0]    idx;
    logic [1:0]          load, clear, bank_valid, bank_mode, valid_next;
    logic [PIX_BITS-1:0] bank_pix [2];
    logic [PIX_BITS-1:0] sel_pix;
    logic                sel_mode;
    logic [PIX_W-1:0]    px [NUM_PIX];
    logic [DATA_W-1:0]   pack_words [PACK_WORDS];
    logic [DATA_W-1:0]   word_c;
    logic [IDX_W-1:0]    last_c;
    logic                save_ok;
    logic                write_enable_q, empty_q, full_q;
    logic [DATA_W-1:0]   write_data_q;

    // Capture decision uses the registered full flag
    assign save_ok = bus.i_save & ~full_q;

    always_comb begin
        load         = '0;
        clear        = '0;
        load[wr_ptr] = save_ok;
        clear[rd_ptr] = (state == ST_RELEASE);
        for (int b = 0; b < 2; b++) begin
            valid_next[b] = load[b] | (bank_valid[b] & ~clear[b]);
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        pwb_bank #(.NUM_PIX(NUM_PIX), .PIX_W(PIX_W)) u_bank (
            .clk     (clk),
            .rst     (rst),
            .load    (load[b]),
            .clear   (clear[b]),
            .pix_in  (bus.i_processed_sum),
            .mode_in (bus.i_pack_mode),
            .pix     (bank_pix[b]),
            .mode    (bank_mode[b]),
            .valid   (bank_valid[b])
        );
    end

    // Word formatter: pixels of the draining bank, packed words built at elaboration
    assign sel_pix  = rd_ptr ? bank_pix[1] : bank_pix[0];
    assign sel_mode = bank_mode[rd_ptr];

    for (genvar k = 0; k < NUM_PIX; k++) begin : g_px
        assign px[k] = sel_pix[k*PIX_W +: PIX_W];
    end

    for (genvar w = 0; w < PACK_WORDS; w++) begin : g_word
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            if (w * LANES + l < NUM_PIX) begin : g_pix
                assign pack_words[w][l*PIX_W +: PIX_W] = px[w*LANES + l];
            end else begin : g_pad
                assign pack_words[w][l*PIX_W +: PIX_W] = '0;
            end
        end
    end

    assign word_c = (sel_mode == MODE_PACK) ? pack_words[idx[PW_IDX_W-1:0]]
                                            : {LANES{px[idx]}};
    assign last_c = (sel_mode == MODE_PACK) ? IDX_W'(PACK_LAST) : IDX_W'(REPL_LAST);

    // Drain FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Drain FSM next state
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:    if (bank_valid[rd_ptr]) state_next = ST_SETUP;
            ST_SETUP:   state_next = ST_STROBE;
            ST_STROBE:  state_next = ST_WAIT;
            ST_WAIT: begin
                if (bus.i_write_complete) begin
                    state_next = (idx == last_c) ? ST_RELEASE : ST_SETUP;
                end
            end
            ST_RELEASE: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Pointers, word index, registered outputs; flags track the post-edge bank state
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr         <= 1'b0;
            rd_ptr         <= 1'b0;
            idx            <= '0;
            write_data_q   <= '0;
            write_enable_q <= 1'b0;
            empty_q        <= 1'b1;
            full_q         <= 1'b0;
        end else begin
            if (save_ok) wr_ptr <= ~wr_ptr;
            if (state == ST_RELEASE) rd_ptr <= ~rd_ptr;
            if (state == ST_IDLE) begin
                idx <= '0;
            end else if (state == ST_WAIT && bus.i_write_complete && idx != last_c) begin
                idx <= idx + IDX_W'(1);
            end
            if (state == ST_SETUP) write_data_q <= word_c;
            write_enable_q <= (state_next == ST_STROBE);
            empty_q        <= ~|valid_next;
            full_q         <= &valid_next;
        end
    end

    assign bus.o_write_data   = write_data_q;
    assign bus.o_write_enable = write_enable_q;
    assign bus.o_empty        = empty_q;
    assign bus.o_full         = full_q;

`ifdef PWB_OVF_CNT_EN
    logic [7:0] ovf_cnt;

    // Saturating count of saves dropped while full
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt <= '0;
        end else if (bus.i_save && full_q && ovf_cnt != 8'hFF) begin
            ovf_cnt <= ovf_cnt + 8'd1;
        end
    end

    assign bus.o_overflow_count = ovf_cnt;
`endif

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Directed bench for pixel_write_buffer: reset, replicate, pack, ping-pong
// overflow, stall / stray completion and reset mid-drain.
module tb_pixel_write_buffer;
    import pwb_pkg::*;

    localparam int unsigned NUM_PIX = 9;
    localparam int unsigned PIX_W   = 8;
    localparam int unsigned DATA_W  = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pixel_write_buffer_if #(.NUM_PIX(NUM_PIX), .PIX_W(PIX_W), .DATA_W(DATA_W)) bus ();

    pixel_write_buffer #(.NUM_PIX(NUM_PIX), .PIX_W(PIX_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int base     = 0;

    logic [DATA_W-1:0] got_q [$];
    logic [DATA_W-1:0] exp_q [$];

    logic auto_ack = 1'b0;
    logic ack_auto = 1'b0;
    logic ack_man  = 1'b0;
    assign bus.i_write_complete = ack_auto | ack_man;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NUM_PIX*PIX_W-1:0] make_pix(input logic [7:0] first,
                                                          input logic [7:0] step);
        logic [NUM_PIX*PIX_W-1:0] v;
        v = '0;
        for (int k = 0; k < int'(NUM_PIX); k++) begin
            v[k*PIX_W +: PIX_W] = first + 8'(k) * step;
        end
        return v;
    endfunction

    task automatic push_repl(input logic [7:0] first, input logic [7:0] step);
        logic [7:0] p;
        for (int k = 0; k < int'(NUM_PIX); k++) begin
            p = first + 8'(k) * step;
            exp_q.push_back({4{p}});
        end
    endtask

    // Called just after a negedge; returns one negedge later with i_save low
    task automatic do_save(input logic [NUM_PIX*PIX_W-1:0] pix, input logic mode);
        bus.i_processed_sum = pix;
        bus.i_pack_mode     = mode;
        bus.i_save          = 1'b1;
        @(negedge clk);
        bus.i_save          = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int k;
        k = 0;
        while (got_q.size() < base + n && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    // Waits for n strobes since base and compares them against exp_q
    task automatic check_stream(input string tag, input int n, input int budget);
        wait_strobes(n, budget);
        check({tag, "_count"}, 32'(got_q.size() - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < got_q.size()) begin
                check($sformatf("%s_word%0d", tag, i), got_q[base + i], exp_q[i]);
            end
        end
    endtask

    // Strobe monitor
    always @(negedge clk) begin
        if (bus.o_write_enable === 1'b1) got_q.push_back(bus.o_write_data);
    end

    // Write controller model: complete two cycles after each strobe
    initial begin
        forever begin
            @(negedge clk);
            if (auto_ack && bus.o_write_enable === 1'b1) begin
                @(negedge clk);
                @(negedge clk);
                ack_auto = 1'b1;
                @(negedge clk);
                ack_auto = 1'b0;
            end
        end
    end

    initial begin
        logic [DATA_W-1:0] held;
        logic              moved;

        rst                 = 1'b1;
        bus.i_save          = 1'b0;
        bus.i_pack_mode     = MODE_REPL;
        bus.i_processed_sum = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_empty", 32'(bus.o_empty), 32'd1);
        check("rst_full", 32'(bus.o_full), 32'd0);
        check("rst_we", 32'(bus.o_write_enable), 32'd0);
        check("rst_data", bus.o_write_data, 32'd0);
`ifdef PWB_OVF_CNT_EN
        check("rst_ovf", 32'(bus.o_overflow_count), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Replicate mode with latency check
        auto_ack = 1'b1;
        base = got_q.size();
        exp_q.delete();
        push_repl(8'h11, 8'h11);
        do_save(make_pix(8'h11, 8'h11), MODE_REPL);
        check("repl_not_empty", 32'(bus.o_empty), 32'd0);
        @(negedge clk);
        check("repl_lat_setup", 32'(bus.o_write_enable), 32'd0);
        @(negedge clk);
        check("repl_lat_strobe", 32'(bus.o_write_enable), 32'd1);
        check("repl_first_data", bus.o_write_data, 32'h11111111);
        check_stream("repl", 9, 300);
        repeat (8) @(negedge clk);
        check("repl_empty_after", 32'(bus.o_empty), 32'd1);

        // Pack mode
        base = got_q.size();
        exp_q.delete();
        exp_q.push_back(32'h44332211);
        exp_q.push_back(32'h88776655);
        exp_q.push_back(32'h00000099);
        do_save(make_pix(8'h11, 8'h11), MODE_PACK);
        check_stream("pack", 3, 200);
        repeat (8) @(negedge clk);
        check("pack_empty_after", 32'(bus.o_empty), 32'd1);

        // Ping-pong: A drains while B waits, C dropped
        base = got_q.size();
        exp_q.delete();
        push_repl(8'h11, 8'h11);
        exp_q.push_back(32'hB4B3B2B1);
        exp_q.push_back(32'hB8B7B6B5);
        exp_q.push_back(32'h000000B9);
        do_save(make_pix(8'h11, 8'h11), MODE_REPL);
        wait_strobes(1, 20);
        do_save(make_pix(8'hB1, 8'h01), MODE_PACK);
        check("pp_full", 32'(bus.o_full), 32'd1);
        check("pp_not_empty", 32'(bus.o_empty), 32'd0);
        do_save(make_pix(8'hC1, 8'h01), MODE_PACK);
        check("pp_full_hold", 32'(bus.o_full), 32'd1);
`ifdef PWB_OVF_CNT_EN
        check("pp_ovf", 32'(bus.o_overflow_count), 32'd1);
`endif
        check_stream("pp", 12, 600);
        repeat (8) @(negedge clk);
        check("pp_empty_after", 32'(bus.o_empty), 32'd1);
        check("pp_no_extra", 32'(got_q.size() - base), 32'd12);

        // Stall in WAIT, then stray completion while idle
        auto_ack = 1'b0;
        base = got_q.size();
        exp_q.delete();
        push_repl(8'h31, 8'h02);
        do_save(make_pix(8'h31, 8'h02), MODE_REPL);
        wait_strobes(1, 20);
        @(negedge clk);
        held  = bus.o_write_data;
        moved = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.o_write_data !== held || bus.o_write_enable !== 1'b0) moved = 1'b1;
        end
        check("stall_strobes", 32'(got_q.size() - base), 32'd1);
        check("stall_data", held, 32'h31313131);
        check("stall_stable", 32'(moved), 32'd0);
        ack_man = 1'b1;
        @(negedge clk);
        ack_man  = 1'b0;
        auto_ack = 1'b1;
        check_stream("stall", 9, 300);
        repeat (10) @(negedge clk);
        ack_man = 1'b1;
        repeat (3) @(negedge clk);
        ack_man = 1'b0;
        repeat (10) @(negedge clk);
        check("stray_no_strobe", 32'(got_q.size() - base), 32'd9);
        check("stray_empty", 32'(bus.o_empty), 32'd1);
        check("stray_we", 32'(bus.o_write_enable), 32'd0);

        // Reset mid-drain after word 4
        base = got_q.size();
        do_save(make_pix(8'h21, 8'h01), MODE_REPL);
        wait_strobes(4, 100);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_rst_strobes", 32'(got_q.size() - base), 32'd4);
        check("mid_rst_empty", 32'(bus.o_empty), 32'd1);
        check("mid_rst_full", 32'(bus.o_full), 32'd0);
        check("mid_rst_we", 32'(bus.o_write_enable), 32'd0);
        check("mid_rst_data", bus.o_write_data, 32'd0);
`ifdef PWB_OVF_CNT_EN
        check("mid_rst_ovf", 32'(bus.o_overflow_count), 32'd0);
`endif
        base = got_q.size();
        exp_q.delete();
        exp_q.push_back(32'h44332211);
        exp_q.push_back(32'h88776655);
        exp_q.push_back(32'h00000099);
        do_save(make_pix(8'h11, 8'h11), MODE_PACK);
        check_stream("restart", 3, 200);
        repeat (8) @(negedge clk);
        check("restart_empty", 32'(bus.o_empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
